// File: rtl/gearbox_align_ctrl.sv
// Word-alignment training controller for one 12-bit LVDS channel, sitting
// behind the 2:1 gearbox in the clk_rxg_x1 domain. It checks the gearbox
// output against the training word, requests phase slips until the word
// lines up, and watches for loss of alignment once locked.
//
// Handshake: data_in is consumed only in cycles where data_valid = 1; there
// is no back-pressure. gear_slip is a one-cycle request to the gearbox.
// All outputs are registered. state_dbg_o exposes the FSM state
// (0 IDLE, 1 SETTLE, 2 CHECK, 3 SLIP, 4 LOCKED, 5 FAIL).
module gearbox_align_ctrl #(
   parameter logic [11:0] TRAIN_WORD = 12'hAB6,
   parameter int unsigned MATCH_CNT  = 16,
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned MAX_SLIPS  = 3,
   parameter int unsigned LOSS_CNT   = 4
) (
   input  logic        clk_rxg_x1,
   input  logic        gear_reset,
   input  logic        train_start,
   input  logic        train_en,
   input  logic        data_valid,
   input  logic [11:0] data_in,
   output logic        gear_slip,
   output logic        locked,
   output logic        align_fail,
   output logic        lock_lost,
   output logic [3:0]  slip_count,
   output logic [2:0]  state_dbg_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_CHECK  = 3'd2,
      S_SLIP   = 3'd3,
      S_LOCKED = 3'd4,
      S_FAIL   = 3'd5
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] MATCH_TGT   = 8'(MATCH_CNT);
   localparam logic [3:0] LOSS_TGT    = 4'(LOSS_CNT);
   localparam logic [3:0] SLIP_LIMIT  = 4'(MAX_SLIPS);

   state_t      state_q;
   logic [7:0]  settle_cnt_q;
   logic [7:0]  match_cnt_q;
   logic [3:0]  err_cnt_q;
   logic [3:0]  slip_cnt_q;
   logic        gear_slip_q;
   logic        locked_q;
   logic        align_fail_q;
   logic        lock_lost_q;

   logic        word_match;
   logic [7:0]  match_cnt_d;
   logic [3:0]  err_cnt_d;
   logic [3:0]  slip_cnt_d;

   // Word compare and incremented counter values; slip count saturates at 15.
   always_comb begin
      word_match  = (data_in == TRAIN_WORD);
      match_cnt_d = match_cnt_q + 8'd1;
      err_cnt_d   = err_cnt_q + 4'd1;
      slip_cnt_d  = (slip_cnt_q == 4'hF) ? slip_cnt_q : slip_cnt_q + 4'd1;
   end

   // Alignment FSM with registered outputs; train_start overrides every state.
   always_ff @(posedge clk_rxg_x1) begin
      if (gear_reset) begin
         state_q      <= S_IDLE;
         settle_cnt_q <= 8'd0;
         match_cnt_q  <= 8'd0;
         err_cnt_q    <= 4'd0;
         slip_cnt_q   <= 4'd0;
         gear_slip_q  <= 1'b0;
         locked_q     <= 1'b0;
         align_fail_q <= 1'b0;
         lock_lost_q  <= 1'b0;
      end else begin
         // Pulse outputs fall back to 0 unless a decision this cycle raises them.
         gear_slip_q <= 1'b0;
         lock_lost_q <= 1'b0;
         if (train_start) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= 8'd0;
            match_cnt_q  <= 8'd0;
            err_cnt_q    <= 4'd0;
            slip_cnt_q   <= 4'd0;
            locked_q     <= 1'b0;
            align_fail_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_IDLE;
               end
               S_SETTLE: begin
                  // Counts clock cycles only; data is not looked at here.
                  if (settle_cnt_q == SETTLE_LAST) begin
                     settle_cnt_q <= 8'd0;
                     state_q      <= S_CHECK;
                  end else begin
                     settle_cnt_q <= settle_cnt_q + 8'd1;
                  end
               end
               S_CHECK: begin
                  if (data_valid) begin
                     if (word_match) begin
                        if (match_cnt_d == MATCH_TGT) begin
                           match_cnt_q <= 8'd0;
                           state_q     <= S_LOCKED;
                        end else begin
                           match_cnt_q <= match_cnt_d;
                        end
                     end else begin
                        match_cnt_q <= 8'd0;
                        if (slip_cnt_q < SLIP_LIMIT) begin
                           // gear_slip is high exactly while the FSM sits in SLIP.
                           state_q     <= S_SLIP;
                           gear_slip_q <= 1'b1;
                           slip_cnt_q  <= slip_cnt_d;
                        end else begin
                           state_q      <= S_FAIL;
                           align_fail_q <= 1'b1;
                        end
                     end
                  end
               end
               S_SLIP: begin
                  settle_cnt_q <= 8'd0;
                  state_q      <= S_SETTLE;
               end
               S_LOCKED: begin
                  // locked follows one edge after the FSM enters LOCKED.
                  locked_q <= 1'b1;
                  if (!train_en) begin
                     err_cnt_q <= 4'd0;
                  end else if (data_valid) begin
                     if (word_match) begin
                        err_cnt_q <= 4'd0;
                     end else if (err_cnt_d == LOSS_TGT) begin
                        // Lock dropped: retrain from the current phase, no slip.
                        locked_q     <= 1'b0;
                        lock_lost_q  <= 1'b1;
                        slip_cnt_q   <= 4'd0;
                        match_cnt_q  <= 8'd0;
                        err_cnt_q    <= 4'd0;
                        settle_cnt_q <= 8'd0;
                        state_q      <= S_SETTLE;
                     end else begin
                        err_cnt_q <= err_cnt_d;
                     end
                  end
               end
               S_FAIL: begin
                  locked_q     <= 1'b0;
                  align_fail_q <= 1'b1;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign gear_slip   = gear_slip_q;
   assign locked      = locked_q;
   assign align_fail  = align_fail_q;
   assign lock_lost   = lock_lost_q;
   assign slip_count  = slip_cnt_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_gearbox_align_ctrl.sv
// Bench for gearbox_align_ctrl: directed scenarios followed by a random run,
// every cycle compared against a behavioural model of the alignment rules.
module tb_gearbox_align_ctrl;

   localparam logic [11:0] TW = 12'hAB6;
   localparam int SETTLE = 8;
   localparam int NMATCH = 16;
   localparam int NSLIPS = 3;
   localparam int NLOSS  = 4;

   // Model phases
   localparam int MD_IDLE   = 0;
   localparam int MD_SETTLE = 1;
   localparam int MD_CHECK  = 2;
   localparam int MD_SLIP   = 3;
   localparam int MD_LOCKED = 4;
   localparam int MD_FAIL   = 5;

   logic        clk;
   logic        rst;
   logic        start;
   logic        en;
   logic        valid;
   logic [11:0] din;
   logic        gear_slip;
   logic        locked;
   logic        align_fail;
   logic        lock_lost;
   logic [3:0]  slip_count;
   logic [2:0]  state_dbg;

   int tests_run = 0;
   int fails = 0;
   int cyc = 0;
   int slip_pulses = 0;
   int lost_pulses = 0;
   int last_slip_cyc = -1;
   int min_gap = 1000;

   // Reference model state
   int   md = MD_IDLE;
   int   settle_left = 0;
   int   good_run = 0;
   int   bad_run = 0;
   int   slips = 0;
   logic e_slip = 1'b0;
   logic e_locked = 1'b0;
   logic e_fail = 1'b0;
   logic e_lost = 1'b0;

   gearbox_align_ctrl dut (
      .clk_rxg_x1  (clk),
      .gear_reset  (rst),
      .train_start (start),
      .train_en    (en),
      .data_valid  (valid),
      .data_in     (din),
      .gear_slip   (gear_slip),
      .locked      (locked),
      .align_fail  (align_fail),
      .lock_lost   (lock_lost),
      .slip_count  (slip_count),
      .state_dbg_o (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge of the alignment rules, applied to the current inputs.
   task automatic model_update();
      if (rst) begin
         md = MD_IDLE; settle_left = 0; good_run = 0; bad_run = 0; slips = 0;
         e_slip = 0; e_locked = 0; e_fail = 0; e_lost = 0;
         return;
      end
      e_slip = 0;
      e_lost = 0;
      if (start) begin
         md = MD_SETTLE; settle_left = SETTLE;
         slips = 0; good_run = 0; bad_run = 0; e_locked = 0; e_fail = 0;
         return;
      end
      if (md == MD_SETTLE) begin
         settle_left--;
         if (settle_left == 0) md = MD_CHECK;
      end else if (md == MD_CHECK) begin
         if (valid) begin
            if (din == TW) begin
               good_run++;
               if (good_run == NMATCH) begin md = MD_LOCKED; good_run = 0; end
            end else begin
               good_run = 0;
               if (slips < NSLIPS) begin
                  md = MD_SLIP; e_slip = 1;
                  slips = (slips < 15) ? slips + 1 : 15;
               end else begin
                  md = MD_FAIL; e_fail = 1;
               end
            end
         end
      end else if (md == MD_SLIP) begin
         md = MD_SETTLE; settle_left = SETTLE;
      end else if (md == MD_LOCKED) begin
         e_locked = 1;
         if (!en) bad_run = 0;
         else if (valid) begin
            if (din == TW) bad_run = 0;
            else begin
               bad_run++;
               if (bad_run == NLOSS) begin
                  e_locked = 0; e_lost = 1; slips = 0; bad_run = 0; good_run = 0;
                  md = MD_SETTLE; settle_left = SETTLE;
               end
            end
         end
      end
   endtask

   // Driver: advance one cycle, update the model, compare away from the edge.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      cyc++;
      chk("gear_slip", {11'd0, gear_slip}, {11'd0, e_slip});
      chk("locked", {11'd0, locked}, {11'd0, e_locked});
      chk("align_fail", {11'd0, align_fail}, {11'd0, e_fail});
      chk("lock_lost", {11'd0, lock_lost}, {11'd0, e_lost});
      chk("slip_count", {8'd0, slip_count}, 12'(slips));
      if (gear_slip === 1'b1) begin
         slip_pulses++;
         if (last_slip_cyc >= 0 && (cyc - last_slip_cyc) < min_gap) min_gap = cyc - last_slip_cyc;
         last_slip_cyc = cyc;
      end
      if (lock_lost === 1'b1) lost_pulses++;
   endtask

   task automatic lock_up();
      en = 1; valid = 1; din = TW; start = 1; step(); start = 0;
      repeat (30) step();
   endtask

   initial begin
      int lat;
      int n;
      rst = 1; start = 0; en = 1; valid = 0; din = 12'd0;

      // Reset state
      repeat (3) step();
      chk("rst_state", {9'd0, state_dbg}, 12'd0);
      rst = 0; step();

      // 1: clean lock, latency from the train_start edge
      slip_pulses = 0;
      valid = 1; din = TW; start = 1; step(); start = 0;
      lat = 0;
      while (locked !== 1'b1 && lat < 60) begin step(); lat++; end
      chk("t1_lock_latency", 12'(lat), 12'd25);
      chk("t1_slips", 12'(slip_pulses), 12'd0);
      chk("t1_slip_count", {8'd0, slip_count}, 12'd0);

      // 2: wrong phase until one slip, then the training word
      slip_pulses = 0;
      din = 12'h55B; start = 1; step(); start = 0;
      n = 0;
      while (gear_slip !== 1'b1 && n < 60) begin step(); n++; end
      chk("t2_slip_seen", {11'd0, gear_slip}, 12'd1);
      din = TW;
      repeat (40) step();
      chk("t2_slips", 12'(slip_pulses), 12'd1);
      chk("t2_slip_count", {8'd0, slip_count}, 12'd1);
      chk("t2_locked", {11'd0, locked}, 12'd1);
      chk("t2_fail", {11'd0, align_fail}, 12'd0);

      // 3: slip budget exhausted
      slip_pulses = 0; last_slip_cyc = -1; min_gap = 1000;
      din = 12'h000; start = 1; step(); start = 0;
      repeat (80) step();
      chk("t3_slips", 12'(slip_pulses), 12'd3);
      chk("t3_gap_ge9", {11'd0, (min_gap >= 9)}, 12'd1);
      chk("t3_fail", {11'd0, align_fail}, 12'd1);
      chk("t3_locked", {11'd0, locked}, 12'd0);
      chk("t3_slip_count", {8'd0, slip_count}, 12'd3);
      start = 1; step(); start = 0;
      chk("t3_fail_cleared", {11'd0, align_fail}, 12'd0);

      // 4: loss monitoring while locked
      lock_up();
      chk("t4_locked", {11'd0, locked}, 12'd1);
      lost_pulses = 0; slip_pulses = 0;
      din = 12'h000; repeat (3) step();
      din = TW; step();
      chk("t4_three_bad_kept", {11'd0, locked}, 12'd1);
      en = 0; din = 12'h000; repeat (4) step();
      chk("t4_en_off_kept", {11'd0, locked}, 12'd1);
      chk("t4_no_loss_yet", 12'(lost_pulses), 12'd0);
      en = 1; repeat (4) step();
      chk("t4_lost_pulse", {11'd0, lock_lost}, 12'd1);
      chk("t4_unlocked", {11'd0, locked}, 12'd0);
      din = TW; repeat (30) step();
      chk("t4_lost_once", 12'(lost_pulses), 12'd1);
      chk("t4_relock_no_slip", 12'(slip_pulses), 12'd0);
      chk("t4_relocked", {11'd0, locked}, 12'd1);

      // 5: data_valid toggling in CHECK, then reset mid-CHECK and mid-SLIP
      din = TW; start = 1; step(); start = 0;
      for (int i = 0; i < 70; i++) begin valid = i[0]; step(); end
      chk("t5_locked_toggle", {11'd0, locked}, 12'd1);
      valid = 1; start = 1; step(); start = 0;
      repeat (12) step();
      rst = 1; step(); rst = 0;
      chk("t5_rst_state", {9'd0, state_dbg}, 12'd0);
      chk("t5_rst_locked", {11'd0, locked}, 12'd0);
      din = 12'h000; start = 1; step(); start = 0;
      n = 0;
      while (gear_slip !== 1'b1 && n < 60) begin step(); n++; end
      rst = 1; step(); rst = 0;
      chk("t5_rst_in_slip", {11'd0, gear_slip}, 12'd0);
      chk("t5_rst_slipcnt", {8'd0, slip_count}, 12'd0);
      step();

      // 6: train_start coincident with the fourth loss mismatch
      lock_up();
      din = 12'h000; repeat (3) step();
      start = 1; step(); start = 0;
      chk("t6_no_lost", {11'd0, lock_lost}, 12'd0);
      chk("t6_unlocked", {11'd0, locked}, 12'd0);
      chk("t6_slip_count", {8'd0, slip_count}, 12'd0);
      din = TW; repeat (30) step();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 79) == 0);
         en    = ($urandom_range(0, 9) != 0);
         valid = ($urandom_range(0, 3) != 0);
         din   = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(0, 4095)) : TW;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
